// File: rtl/matrix_mem_arbiter_pkg.sv
// Shared constants for the matrix storage arbiter: requester indices,
// storage geometry defaults and arbiter state encoding.
package matrix_mem_arbiter_pkg;

    localparam int REQ_INPUT  = 0;
    localparam int REQ_RANDOM = 1;
    localparam int REQ_ALU    = 2;
    localparam int REQ_DISP   = 3;
    localparam int NUM_REQ    = 4;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_DEPTH  = 1000;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/matrix_mem_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request searching upward from
// owner_id+1 with wrap, so the previous owner is always considered last.
module matrix_mem_arbiter_rr_pick4 (
    input  logic [3:0] ereq,
    input  logic [1:0] owner_id,
    output logic [1:0] win,
    output logic       win_vld
);

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int o = 1; o <= 4; o++) begin
            if (!win_vld && ereq[owner_id + 2'(o)]) begin
                win_vld = 1'b1;
                win     = owner_id + 2'(o);
            end
        end
    end

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter sharing the single-port matrix storage RAM among four
// requesters. Optional ARB_HOLD_LIMIT_EN forces release after HOLD_LIMIT beats.
module matrix_mem_arbiter
    import matrix_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = ARB_DEPTH
`ifdef ARB_HOLD_LIMIT_EN
    ,
    parameter int HOLD_LIMIT = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            req_mask,
    input  logic [3:0]            we,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    output logic [3:0]            gnt,
    output logic [3:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  addr_err,
    output logic [1:0]            owner_id,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_e         state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [3:0]         rvalid_q, rvalid_d;
    logic               addr_err_q, addr_err_d;
    logic [1:0]         owner_q, owner_d;

    logic [3:0]         ereq;
    logic [1:0]         pick_win;
    logic               pick_vld;
    logic [ADDR_W-1:0]  addr_a  [4];
    logic [DATA_W-1:0]  wdata_a [4];
    logic [ADDR_W-1:0]  cur_addr;
    logic               cur_we;
    logic               beat;
    logic               in_range;
    logic               preempt;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    end

    assign ereq     = req & req_mask;
    assign cur_addr = addr_a[owner_q];
    assign cur_we   = we[owner_q];
    assign beat     = gnt_q[owner_q] & ereq[owner_q];
    assign in_range = 32'(cur_addr) < 32'(DEPTH);

    matrix_mem_arbiter_rr_pick4 u_pick (
        .ereq     (ereq),
        .owner_id (owner_q),
        .win      (pick_win),
        .win_vld  (pick_vld)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Every grant starts from IDLE, so clearing there restarts the count per grant.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE)
            cnt_d = '0;
        else if (beat && cnt_q != CNT_W'(HOLD_LIMIT))
            cnt_d = cnt_q + 1'b1;
    end

    assign preempt = beat && (cnt_q >= CNT_W'(HOLD_LIMIT - 1)) && |(ereq & ~gnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rvalid_d   = '0;
        addr_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_GRANTED;
                    gnt_d   = 4'b0001 << pick_win;
                    owner_d = pick_win;
                end
            end
            ARB_GRANTED: begin
                // No same-cycle handover: release always passes through IDLE.
                if (!ereq[owner_q] || preempt) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (beat && in_range && !cur_we) rvalid_d[owner_q] = 1'b1;
        if (beat && !in_range)           addr_err_d        = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            addr_err_q <= 1'b0;
            owner_q    <= 2'(REQ_DISP);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            owner_q    <= owner_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign addr_err  = addr_err_q;
    assign owner_id  = owner_q;
    assign busy      = |gnt_q;
    assign rdata     = mem_rdata;
    assign mem_en    = beat & in_range;
    assign mem_we    = beat & in_range & cur_we;
    assign mem_addr  = beat ? cur_addr : '0;
    assign mem_wdata = beat ? wdata_a[owner_q] : '0;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Directed self-checking bench for matrix_mem_arbiter with a 1-cycle-latency
// RAM model; covers both the default build and ARB_HOLD_LIMIT_EN.
module tb_matrix_mem_arbiter;
    import matrix_mem_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req = '0, req_mask = '0, we = '0;
    logic [4*AW-1:0] addr = '0;
    logic [4*DW-1:0] wdata = '0;
    logic [3:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            addr_err, busy, mem_en, mem_we;
    logic [1:0]      owner_id;
    logic [AW-1:0]   mem_addr;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   ram [1024];
    logic [DW-1:0]   ram_rd = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_rd        <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_rd;

    matrix_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(1000)
`ifdef ARB_HOLD_LIMIT_EN
        , .HOLD_LIMIT(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_mask(req_mask), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .addr_err(addr_err), .owner_id(owner_id), .busy(busy), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = r;
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        req_mask = 4'hF;
        #2 rst = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (owner_id !== 2'd3) begin bad++; $display("FAIL reset_owner got=%0d exp=3", owner_id); end
        total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL reset_mem_ctl got=%b exp=00", {mem_en, mem_we}); end
        total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(REQ_INPUT, 1'b1, 1'b1, 10'd5, 32'h1234);
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        total++; if (owner_id !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL single_owner got=%0d/%b exp=0/1", owner_id, busy); end
        total++; if ({mem_en, mem_we} !== 2'b11) begin bad++; $display("FAIL single_mem_ctl got=%b exp=11", {mem_en, mem_we}); end
        total++; if (mem_addr !== 10'd5 || mem_wdata !== 32'h1234) begin bad++; $display("FAIL single_mem_bus got=%0d/%h exp=5/1234", mem_addr, mem_wdata); end
        tick();
        req[REQ_INPUT] = 1'b0;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", gnt); end
        drive(REQ_DISP, 1'b1, 1'b0, 10'd5, 32'h0);
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rd_gnt got=%b exp=1000", gnt); end
        total++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'd5) begin bad++; $display("FAIL rd_mem got=%b/%0d exp=10/5", {mem_en, mem_we}, mem_addr); end
        tick();
        total++; if (rvalid !== 4'b1000) begin bad++; $display("FAIL rd_rvalid got=%b exp=1000", rvalid); end
        total++; if (rdata !== 32'h1234) begin bad++; $display("FAIL rd_rdata got=%h exp=1234", rdata); end
        req[REQ_DISP] = 1'b0;
        tick();
        total++; if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin bad++; $display("FAIL rd_done got=%b/%b exp=0000/0000", gnt, rvalid); end
    endtask

    task automatic test_round_robin();
        int         exp_o [5];
        logic [3:0] e;
        exp_o = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0, 10'(20 + i), 32'h0);
        for (int n = 0; n < 5; n++) begin
            tick();
            e = 4'b0001 << exp_o[n];
            total++; if (gnt !== e || owner_id !== 2'(exp_o[n])) begin bad++; $display("FAIL rr_gnt[%0d] got=%b/%0d exp=%b/%0d", n, gnt, owner_id, e, exp_o[n]); end
            tick();
            req[exp_o[n]] = 1'b0;
            tick();
            total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_idle[%0d] got=%b exp=0000", n, gnt); end
            req[exp_o[n]] = 1'b1;
        end
        req = '0;
        tick();
    endtask

    task automatic test_mask();
        req_mask = 4'b1011;
        drive(REQ_ALU, 1'b1, 1'b0, 10'd7, 32'h0);
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mask_block0 got=%b exp=0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mask_block1 got=%b exp=0000", gnt); end
        req_mask = 4'hF;
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mask_open got=%b exp=0100", gnt); end
        tick();
        req_mask = 4'b1011;
        #1;
        total++; if (rvalid !== 4'b0100) begin bad++; $display("FAIL mask_inflight got=%b exp=0100", rvalid); end
        tick();
        total++; if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin bad++; $display("FAIL mask_drop got=%b/%b exp=0000/0000", gnt, rvalid); end
        req[REQ_ALU] = 1'b0;
        req_mask     = 4'hF;
        tick();
    endtask

    task automatic test_out_of_range();
        drive(REQ_RANDOM, 1'b1, 1'b1, 10'd1000, 32'hDEAD);
        tick();
        total++; if (gnt !== 4'b0010 || mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL oor_beat got=%b/%b/%b exp=0010/0/0", gnt, mem_en, mem_we); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_early got=%b exp=0", addr_err); end
        tick();
        total++; if (addr_err !== 1'b1 || gnt !== 4'b0010) begin bad++; $display("FAIL oor_err got=%b/%b exp=1/0010", addr_err, gnt); end
        drive(REQ_RANDOM, 1'b1, 1'b1, 10'd999, 32'hBEEF);
        #1;
        total++; if (mem_en !== 1'b1 || mem_addr !== 10'd999) begin bad++; $display("FAIL oor_edge got=%b/%0d exp=1/999", mem_en, mem_addr); end
        tick();
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_edge_err got=%b exp=0", addr_err); end
        drive(REQ_RANDOM, 1'b1, 1'b0, 10'd1023, 32'h0);
        tick();
        total++; if (addr_err !== 1'b1 || rvalid !== 4'b0000) begin bad++; $display("FAIL oor_read got=%b/%b exp=1/0000", addr_err, rvalid); end
        req[REQ_RANDOM] = 1'b0;
        tick();
        total++; if (gnt !== 4'b0000 || addr_err !== 1'b0) begin bad++; $display("FAIL oor_done got=%b/%b exp=0000/0", gnt, addr_err); end
    endtask

    task automatic test_reset_mid_read();
        drive(REQ_DISP, 1'b1, 1'b0, 10'd5, 32'h0);
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rmr_gnt got=%b exp=1000", gnt); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin bad++; $display("FAIL rmr_clear got=%b/%b exp=0000/0000", gnt, rvalid); end
        total++; if (owner_id !== 2'd3 || busy !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL rmr_state got=%0d/%b/%b exp=3/0/0", owner_id, busy, mem_en); end
        drive(REQ_INPUT, 1'b1, 1'b0, 10'd5, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        total++; if (gnt !== 4'b0001 || owner_id !== 2'd0) begin bad++; $display("FAIL rmr_first got=%b/%0d exp=0001/0", gnt, owner_id); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_hold_limit();
        drive(REQ_INPUT, 1'b1, 1'b0, 10'd30, 32'h0);
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_gnt got=%b exp=0001", gnt); end
        drive(REQ_RANDOM, 1'b1, 1'b0, 10'd31, 32'h0);
        tick(); tick(); tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_beat4 got=%b exp=0001", gnt); end
        tick();
`ifdef ARB_HOLD_LIMIT_EN
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL hold_release got=%b exp=0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL hold_next got=%b exp=0010", gnt); end
`else
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_keep got=%b exp=0001", gnt); end
`endif
        req = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_out_of_range();
        test_reset_mid_read();
        test_hold_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
